axi_master_tx: RTL

- Transmit side of the team's 32-bit valid/ready message link. It drives `valid_o`/`message_o` into the receiving slave and waits for that slave's `ready`.
- The processor core pushes messages into a small internal FIFO. The block drains the FIFO one handshake at a time.
- A watchdog drops a message if the slave never becomes ready. An error flag records the drop.
- The block sits between the core's message-send port and the link to the peer slave.

---
 rtl/axi_pkg.sv | 23 ++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/axi_master_tx.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared constants and types for the valid/ready message link
//                transmitter: default message width, default watchdog limit
//                and the transmit FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_pkg;

  localparam int AXI_DATA_W  = 32;   // default message width in bits
  localparam int AXI_TIMEOUT = 256;  // default watchdog limit in cycles

  typedef enum logic [1:0] {
    IDLE  = 2'd0,  // link idle, waiting for FIFO data
    DRIVE = 2'd1,  // valid_o asserted, waiting for ready_i
    DROP  = 2'd2   // one forced idle cycle after a watchdog drop
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with wrap-bit pointers.
//                Ports:
//                  clk_i / reset_i    clock, synchronous active-high reset
//                  push_i / data_i    enqueue request and data (ignored if full)
//                  pop_i              dequeue request (ignored if empty)
//                  head_o             data at the read pointer
//                  full_o / empty_o   status derived from registered pointers
//                  level_o            number of stored entries
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q;
  logic [AW:0]       rd_ptr_q;
  logic              push_en;
  logic              pop_en;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  assign push_en = push_i && !full_o;
  assign pop_en  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + C_PTR_ONE;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + C_PTR_ONE;
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (push_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

`default_nettype wire

// File: rtl/axi_master_tx.sv
// ============================================================================
//  Module      : axi_master_tx
//  Description : Transmit side of the 32-bit valid/ready message link. The
//                core pushes messages into a small FIFO; an FSM drains it
//                into a registered output stage, one handshake per message.
//                A watchdog drops the head message if the slave stalls.
//                Ports:
//                  clk_i / reset_i       clock, synchronous active-high reset
//                  message_i / push_i    core enqueue interface
//                  push_ready_o          FIFO not full
//                  level_o               FIFO entries (output stage excluded)
//                  message_o / valid_o   registered link outputs
//                  ready_i               link ready from the slave
//                  done_o                one-cycle pulse per handshake
//                  busy_o                FIFO non-empty or valid_o high
//                  err_o / clr_err_i     sticky timeout flag and its clear
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_master_tx
  import axi_pkg::*;
#(
  parameter int DATA_W  = AXI_DATA_W,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = AXI_TIMEOUT
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [DATA_W-1:0]        message_i,
  input  logic                     push_i,
  output logic                     push_ready_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic [DATA_W-1:0]        message_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic                     done_o,
  output logic                     busy_o,
  output logic                     err_o,
  input  logic                     clr_err_i
);

  // The counter never needs to exceed TIMEOUT-1, so clog2(TIMEOUT) bits suffice.
  localparam int              WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] C_WD_MAX = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [WD_W-1:0] C_WD_ONE = WD_W'(1);
  localparam bit              C_WD_EN  = (TIMEOUT != 0);

  state_e              state_q;
  logic [DATA_W-1:0]   message_q;
  logic                valid_q;
  logic                done_q;
  logic                err_q;
  logic [WD_W-1:0]     wd_q;

  logic [DATA_W-1:0]   fifo_head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;

  // Pop whenever the output stage is about to load a new head: from IDLE, or
  // on a handshake in DRIVE so back-to-back messages go out every cycle.
  assign fifo_pop = !fifo_empty &&
                    ((state_q == IDLE) || ((state_q == DRIVE) && ready_i));

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push_i),
    .data_i  (message_i),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      message_q <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      wd_q      <= '0;
    end else begin
      done_q <= 1'b0;
      // A clear is overridden below by a timeout on the same edge.
      if (clr_err_i) err_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          wd_q <= '0;
          if (!fifo_empty) begin
            message_q <= fifo_head;
            valid_q   <= 1'b1;
            state_q   <= DRIVE;
          end
        end

        DRIVE: begin
          if (ready_i) begin
            // Handshake has priority over a timeout on the same edge.
            done_q <= 1'b1;
            wd_q   <= '0;
            if (!fifo_empty) begin
              message_q <= fifo_head;
            end else begin
              message_q <= '0;
              valid_q   <= 1'b0;
              state_q   <= IDLE;
            end
          end else if (C_WD_EN && (wd_q == C_WD_MAX)) begin
            message_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b1;
            wd_q      <= '0;
            state_q   <= DROP;
          end else if (C_WD_EN) begin
            wd_q <= wd_q + C_WD_ONE;
          end
        end

        DROP: begin
          state_q <= IDLE;
        end

        default: begin
          message_q <= '0;
          valid_q   <= 1'b0;
          wd_q      <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign message_o    = message_q;
  assign valid_o      = valid_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign push_ready_o = !fifo_full;
  assign busy_o       = !fifo_empty || valid_q;

endmodule

`default_nettype wire
